// File: rtl/vga_pkg.sv
// Shared VGA timing constants, totals helpers and RGB444 field layout.
// Used by the timing generator and by anything that needs the default 640x480@60 numbers.
package vga_pkg;

    localparam int CNT_W     = 10;
    localparam int CNT_LIMIT = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // pixel word is {B[3:0],G[3:0],R[3:0]}
    localparam int RGB_W     = 12;
    localparam int CH_W      = 4;
    localparam int RGB_R_LSB = 0;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_B_LSB = 8;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctl_t;

    function automatic int h_total(input int h_active, input int h_fp, input int h_sync,
                                   input int h_bp);
        return h_active + h_fp + h_sync + h_bp;
    endfunction

    function automatic int v_total(input int v_active, input int v_fp, input int v_sync,
                                   input int v_bp);
        return v_active + v_fp + v_sync + v_bp;
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int first,
                                       input int len);
        return (int'(cnt) >= first) && (int'(cnt) < first + len);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register whose stages all load RESET_VAL on reset; used to align the
// control flags {de,hs,vs,fs} with pixel data returned by the pixel source.
module vga_delay_line #(
    parameter int              WIDTH     = 4,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             vga_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;

        if (gi == 0) begin : g_first
            always_ff @(posedge vga_clk or negedge vga_rst) begin
                if (!vga_rst) begin
                    q_reg <= RESET_VAL;
                end else begin
                    q_reg <= din;
                end
            end
        end else begin : g_rest
            always_ff @(posedge vga_clk or negedge vga_rst) begin
                if (!vga_rst) begin
                    q_reg <= RESET_VAL;
                end else begin
                    q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    end

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel sink: counters publish x/y to the pixel source,
// returned pixels are blanked and registered together with delayed hs/vs/frame_start.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIX_LAT  = 1
) (
    input  logic              vga_clk,
    input  logic              vga_rst,
    output logic [CNT_W-1:0]  x_pos,
    output logic [CNT_W-1:0]  y_pos,
    output logic              pix_req,
    input  logic [RGB_W-1:0]  pixel_data,
    output logic [CH_W-1:0]   vga_r,
    output logic [CH_W-1:0]   vga_g,
    output logic [CH_W-1:0]   vga_b,
    output logic              hs,
    output logic              vs,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam vga_ctl_t CTL_RESET = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0};

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
        $error("vga_ctrl: H_TOTAL=%0d / V_TOTAL=%0d do not fit 10-bit counters", H_TOTAL, V_TOTAL);
    end
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
        $error("vga_ctrl: PIX_LAT=%0d outside 1..4", PIX_LAT);
    end

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg;
    logic [CNT_W-1:0] v_cnt_next;

    always_comb begin
        h_cnt_next = h_cnt_reg + 1'b1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // Stage 0: flags belonging to the coordinate currently on x_pos/y_pos
    vga_ctl_t ctl0;
    vga_ctl_t ctl_d;

    always_comb begin
        ctl0.de = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
        ctl0.hs = in_window(h_cnt_reg, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        ctl0.vs = in_window(v_cnt_reg, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        ctl0.fs = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end

    vga_delay_line #(
        .WIDTH     ($bits(vga_ctl_t)),
        .DEPTH     (PIX_LAT),
        .RESET_VAL (CTL_RESET)
    ) u_ctl_delay (
        .vga_clk (vga_clk),
        .vga_rst (vga_rst),
        .din     (ctl0),
        .dout    (ctl_d)
    );

    logic [RGB_W-1:0] rgb_reg;
    logic             hs_reg;
    logic             vs_reg;
    logic             fs_reg;

    // Blanked positions never forward pixel_data, so X/garbage from the source stays off the pins
    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            rgb_reg <= '0;
            hs_reg  <= ~SYNC_POL;
            vs_reg  <= ~SYNC_POL;
            fs_reg  <= 1'b0;
        end else begin
            rgb_reg <= ctl_d.de ? pixel_data : '0;
            hs_reg  <= ctl_d.hs;
            vs_reg  <= ctl_d.vs;
            fs_reg  <= ctl_d.fs;
        end
    end

    assign x_pos       = h_cnt_reg;
    assign y_pos       = v_cnt_reg;
    assign pix_req     = ctl0.de;
    assign vga_r       = rgb_reg[RGB_R_LSB +: CH_W];
    assign vga_g       = rgb_reg[RGB_G_LSB +: CH_W];
    assign vga_b       = rgb_reg[RGB_B_LSB +: CH_W];
    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: instance 0 uses the 640x480 defaults, instance 1 a tiny raster
// with SYNC_POL=1 and PIX_LAT=3, each fed by a pattern stub of matching latency.
module tb_vga_ctrl;

    localparam int   HA [2] = '{640, 16};
    localparam int   HF [2] = '{16, 2};
    localparam int   HS [2] = '{96, 4};
    localparam int   HB [2] = '{48, 3};
    localparam int   VA [2] = '{480, 10};
    localparam int   VF [2] = '{10, 1};
    localparam int   VS [2] = '{2, 2};
    localparam int   VB [2] = '{33, 2};
    localparam logic POL [2] = '{1'b0, 1'b1};
    localparam int   LAT [2] = '{1, 3};

    typedef struct {
        int         due;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } pin_t;

    typedef struct {
        int         due;
        logic [9:0] x;
        logic [9:0] y;
        logic       req;
    } cnt_t;

    logic        vga_clk;
    logic        rst [2];
    logic [9:0]  xp [2];
    logic [9:0]  yp [2];
    logic        req [2];
    logic [11:0] pix [2];
    logic [3:0]  vr [2];
    logic [3:0]  vg [2];
    logic [3:0]  vb [2];
    logic        hsp [2];
    logic        vsp [2];
    logic        fsp [2];

    logic        force_fff;
    logic [11:0] stub_a_reg;
    logic [11:0] stub_b1_reg;
    logic [11:0] stub_b2_reg;
    logic [11:0] stub_b3_reg;

    int cyc [2];
    int n_pass;
    int n_total;

    pin_t q_pin [2][$];
    cnt_t q_cnt [2][$];

    vga_ctrl #(
        .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .SYNC_POL(POL[0]), .PIX_LAT(LAT[0])
    ) u_dut_a (
        .vga_clk(vga_clk), .vga_rst(rst[0]), .x_pos(xp[0]), .y_pos(yp[0]),
        .pix_req(req[0]), .pixel_data(pix[0]), .vga_r(vr[0]), .vga_g(vg[0]),
        .vga_b(vb[0]), .hs(hsp[0]), .vs(vsp[0]), .frame_start(fsp[0])
    );

    vga_ctrl #(
        .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .SYNC_POL(POL[1]), .PIX_LAT(LAT[1])
    ) u_dut_b (
        .vga_clk(vga_clk), .vga_rst(rst[1]), .x_pos(xp[1]), .y_pos(yp[1]),
        .pix_req(req[1]), .pixel_data(pix[1]), .vga_r(vr[1]), .vga_g(vg[1]),
        .vga_b(vb[1]), .hs(hsp[1]), .vs(vsp[1]), .frame_start(fsp[1])
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Pattern stubs: one register for PIX_LAT=1, three for PIX_LAT=3
    always @(posedge vga_clk) begin
        stub_a_reg  <= {xp[0][3:0], yp[0][3:0], 4'h0};
        stub_b1_reg <= {xp[1][3:0], yp[1][3:0], 4'h0};
        stub_b2_reg <= stub_b1_reg;
        stub_b3_reg <= stub_b2_reg;
    end
    assign pix[0] = force_fff ? 12'hFFF : stub_a_reg;
    assign pix[1] = force_fff ? 12'hFFF : stub_b3_reg;

    // Clock edges seen since reset release
    always @(posedge vga_clk or negedge rst[0]) begin
        if (!rst[0]) cyc[0] <= 0;
        else         cyc[0] <= cyc[0] + 1;
    end
    always @(posedge vga_clk or negedge rst[1]) begin
        if (!rst[1]) cyc[1] <= 0;
        else         cyc[1] <= cyc[1] + 1;
    end

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, id, cyc[id], act, exp);
    endtask

    // Expected pins for raster index k (k<0: delay stages still hold reset contents)
    function automatic pin_t model_pin(input int id, input int k, input int due);
        pin_t p;
        int   ht, vt, x, y;
        p.due = due;
        p.rgb = '0;
        p.hs  = ~POL[id];
        p.vs  = ~POL[id];
        p.fs  = 1'b0;
        if (k >= 0) begin
            ht = HA[id] + HF[id] + HS[id] + HB[id];
            vt = VA[id] + VF[id] + VS[id] + VB[id];
            x  = k % ht;
            y  = (k / ht) % vt;
            if (x < HA[id] && y < VA[id]) p.rgb = {x[3:0], y[3:0], 4'h0};
            if (x >= HA[id] + HF[id] && x < HA[id] + HF[id] + HS[id]) p.hs = POL[id];
            if (y >= VA[id] + VF[id] && y < VA[id] + VF[id] + VS[id]) p.vs = POL[id];
            p.fs = (x == 0) && (y == 0);
        end
        return p;
    endfunction

    function automatic cnt_t model_cnt(input int id, input int n);
        cnt_t c;
        int   ht, vt, x, y;
        ht    = HA[id] + HF[id] + HS[id] + HB[id];
        vt    = VA[id] + VF[id] + VS[id] + VB[id];
        x     = n % ht;
        y     = (n / ht) % vt;
        c.due = n;
        c.x   = x[9:0];
        c.y   = y[9:0];
        c.req = (x < HA[id]) && (y < VA[id]);
        return c;
    endfunction

    // Issues one raster index per edge and queues the response expected later
    task automatic producer(input int id);
        bit live = 1'b0;
        forever begin
            @(posedge vga_clk);
            #1;
            if (!rst[id]) begin
                q_pin[id].delete();
                q_cnt[id].delete();
                live = 1'b0;
            end else begin
                if (!live) begin
                    for (int k = -LAT[id]; k <= 0; k++)
                        q_pin[id].push_back(model_pin(id, k, k + LAT[id] + 1));
                    live = 1'b1;
                end
                q_cnt[id].push_back(model_cnt(id, cyc[id]));
                q_pin[id].push_back(model_pin(id, cyc[id], cyc[id] + LAT[id] + 1));
            end
        end
    endtask

    task automatic monitor(input int id);
        pin_t p;
        cnt_t c;
        forever begin
            @(negedge vga_clk);
            if (rst[id]) begin
                while (q_cnt[id].size() > 0 && q_cnt[id][0].due <= cyc[id]) begin
                    c = q_cnt[id].pop_front();
                    check("xy_req", id, {11'b0, xp[id], yp[id], req[id]}, {11'b0, c.x, c.y, c.req});
                end
                while (q_pin[id].size() > 0 && q_pin[id][0].due <= cyc[id]) begin
                    p = q_pin[id].pop_front();
                    check("rgb", id, {20'b0, vb[id], vg[id], vr[id]}, {20'b0, p.rgb});
                    check("sync", id, {30'b0, hsp[id], vsp[id]}, {30'b0, p.hs, p.vs});
                    check("frame_start", id, {31'b0, fsp[id]}, {31'b0, p.fs});
                end
            end
        end
    endtask

    initial producer(0);
    initial producer(1);
    initial monitor(0);
    initial monitor(1);

    function automatic logic sig(input int id, input int sel);
        case (sel)
            0:       return hsp[id];
            1:       return vsp[id];
            default: return fsp[id];
        endcase
    endfunction

    // Cycle at which the chosen pin reaches lvl, or -1 when the budget expires
    task automatic find_level(input int id, input int sel, input logic lvl, input int limit,
                              output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge vga_clk);
            if (sig(id, sel) === lvl) begin
                at = cyc[id];
                break;
            end
        end
    endtask

    task automatic wait_cyc(input int id, input int target);
        for (int i = 0; i < 50000 && cyc[id] < target; i++) @(negedge vga_clk);
    endtask

    task automatic check_reset(input int id);
        check("rst_rgb", id, {20'b0, vb[id], vg[id], vr[id]}, 32'h0);
        check("rst_sync", id, {30'b0, hsp[id], vsp[id]}, {30'b0, ~POL[id], ~POL[id]});
        check("rst_fs", id, {31'b0, fsp[id]}, 32'h0);
        check("rst_xy", id, {12'b0, xp[id], yp[id]}, 32'h0);
    endtask

    task automatic release_rst(input int id);
        @(negedge vga_clk);
        #5 rst[id] = 1'b1;
    endtask

    task automatic dir_a_timing();
        int at;
        find_level(0, 0, 1'b0, 2000, at);
        check("a_hs_first_fall", 0, at, 658);
        find_level(0, 0, 1'b1, 2000, at);
        check("a_hs_rise", 0, at, 754);
        find_level(0, 0, 1'b0, 2000, at);
        check("a_hs_second_fall", 0, at, 1458);
    endtask

    task automatic dir_b_timing();
        int at;
        find_level(1, 2, 1'b1, 1000, at);
        check("b_fs_first", 1, at, 4);
        find_level(1, 2, 1'b0, 1000, at);
        check("b_fs_width", 1, at, 5);
        find_level(1, 0, 1'b1, 1000, at);
        check("b_hs_assert", 1, at, 22);
        find_level(1, 0, 1'b0, 1000, at);
        check("b_hs_deassert", 1, at, 26);
    endtask

    initial begin
        int at;
        n_pass    = 0;
        n_total   = 0;
        force_fff = 1'b1;
        rst[0]    = 1'b1;
        rst[1]    = 1'b1;
        #5;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset held 10 cycles with all-ones pixel data
        repeat (10) begin
            @(negedge vga_clk);
            check_reset(0);
            check_reset(1);
        end
        force_fff = 1'b0;
        @(negedge vga_clk);
        #5;
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        fork
            begin
                dir_a_timing();
                wait_cyc(0, 4039);
                check("a_px37_5_b", 0, {28'b0, vb[0]}, 32'h5);
                check("a_px37_5_g", 0, {28'b0, vg[0]}, 32'h5);
                check("a_px37_5_r", 0, {28'b0, vr[0]}, 32'h0);
                wait_cyc(0, 4641);
                check("a_px639_5", 0, {20'b0, vb[0], vg[0], vr[0]}, 32'hF50);
                wait_cyc(0, 4642);
                check("a_px640_blank", 0, {20'b0, vb[0], vg[0], vr[0]}, 32'h0);
            end
            begin
                dir_b_timing();
                wait_cyc(1, 84);
                check("b_px5_3", 1, {20'b0, vb[1], vg[1], vr[1]}, 32'h530);
                find_level(1, 1, 1'b1, 1000, at);
                check("b_vs_assert", 1, at, 279);
                find_level(1, 1, 1'b0, 1000, at);
                check("b_vs_deassert", 1, at, 329);
                find_level(1, 2, 1'b1, 1000, at);
                check("b_fs_second", 1, at, 379);
            end
        join

        // Mid-line reset on the default raster
        at = -1;
        for (int i = 0; i < 40000; i++) begin
            @(negedge vga_clk);
            if (xp[0] == 10'd300 && yp[0] == 10'd30) begin
                at = i;
                break;
            end
        end
        check("a_reach_300_30", 0, {31'b0, at >= 0}, 32'h1);
        #5 rst[0] = 1'b0;
        #1 check_reset(0);
        repeat (3) begin
            @(negedge vga_clk);
            check_reset(0);
        end
        release_rst(0);
        dir_a_timing();

        // Mid-frame reset on the small raster
        at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge vga_clk);
            if (xp[1] == 10'd10 && yp[1] == 10'd5) begin
                at = i;
                break;
            end
        end
        check("b_reach_10_5", 1, {31'b0, at >= 0}, 32'h1);
        #5 rst[1] = 1'b0;
        #1 check_reset(1);
        repeat (3) begin
            @(negedge vga_clk);
            check_reset(1);
        end
        release_rst(1);
        dir_b_timing();

        repeat (800) @(negedge vga_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
